// File: rtl/adder_sched_pkg.sv
// Shared types and defaults for the round-robin adder scheduler.
package adder_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREQ  = 4;
    localparam int STAT_W    = 16;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/adder_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod NREQ.
module adder_rr_pick
    import adder_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[wrap_idx(ptr, k)]) begin
                any                     = 1'b1;
                idx                     = wrap_idx(ptr, k);
                onehot[wrap_idx(ptr, k)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_rr_scheduler.sv
// One registered adder shared round-robin by NREQ requesters; accept T -> rsp_valid T+2, stalls in RESP while !rsp_ready.
// Optional completion counters under ADDER_SCHED_STATS_EN (otherwise stat_* tie to 0).
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NREQ  = DEF_NREQ,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_ci,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_co,
    output logic [STAT_W-1:0]       stat_ops,
    output logic [STAT_W-1:0]       stat_cos
);

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   op_id;
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_ci;
    logic [NREQ-1:0]  pick_onehot;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic             accept, rsp_fire;

    adder_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    req_ready = pick_onehot;
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_fire  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Reset overrides every handshake, even in the cycle it is first seen.
        if (rst) begin
            req_ready = '0;
            rsp_valid = 1'b0;
            accept    = 1'b0;
            rsp_fire  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            op_id   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_ci   <= 1'b0;
            rsp_id  <= '0;
            rsp_sum <= '0;
            rsp_co  <= 1'b0;
        end else begin
            if (accept) begin
                op_a  <= req_a[int'(pick_idx)*WIDTH +: WIDTH];
                op_b  <= req_b[int'(pick_idx)*WIDTH +: WIDTH];
                op_ci <= req_ci[pick_idx];
                op_id <= pick_idx;
            end
            if (state == ST_EXEC) begin
                {rsp_co, rsp_sum} <= {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_ci};
                rsp_id            <= op_id;
            end
            if (rsp_fire)
                rr_ptr <= (op_id == IDW'(NREQ - 1)) ? '0 : op_id + IDW'(1);
        end
    end

`ifdef ADDER_SCHED_STATS_EN
    logic [STAT_W-1:0] ops_q, cos_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ops_q <= '0;
            cos_q <= '0;
        end else if (rsp_fire) begin
            ops_q <= sat_inc(ops_q);
            if (rsp_co) cos_q <= sat_inc(cos_q);
        end
    end

    assign stat_ops = ops_q;
    assign stat_cos = cos_q;
`else
    assign stat_ops = '0;
    assign stat_cos = '0;
`endif

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed and randomized checks of the shared round-robin adder scheduler (NREQ=4, WIDTH=32).
module tb_adder_rr_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a, req_b;
    logic [3:0]   req_ci;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic         rsp_co;
    logic [15:0]  stat_ops, stat_cos;

    int checks = 0;
    int errors = 0;
    int exp_ops = 0;
    int exp_cos = 0;
    int mptr;

    adder_rr_scheduler #(.WIDTH(32), .NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ci    (req_ci),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_co    (rsp_co),
        .stat_ops  (stat_ops),
        .stat_cos  (stat_cos)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s disagreed", tag);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic ci);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_ci[i]         = ci;
    endtask

    task automatic check_stats(input string tag);
`ifdef ADDER_SCHED_STATS_EN
        check({tag, "_ops"}, 64'(stat_ops), 64'(exp_ops));
        check({tag, "_cos"}, 64'(stat_cos), 64'(exp_cos));
`else
        check({tag, "_ops"}, 64'(stat_ops), 64'd0);
        check({tag, "_cos"}, 64'(stat_cos), 64'd0);
`endif
    endtask

    // Full accept -> EXEC -> RESP -> handshake sequence, optional rsp_ready stall in RESP.
    task automatic do_op(input logic [3:0] g, input logic [1:0] id, input logic [31:0] s,
                         input logic c, input int stall);
        #1;
        check("grant", 64'(req_ready), 64'(g));
        tick();
        check("exec_ready", 64'(req_ready), 64'd0);
        check("exec_valid", 64'(rsp_valid), 64'd0);
        if (stall > 0) rsp_ready = 1'b0;
        tick();
        for (int n = 0; n < stall; n++) begin
            check("stall_valid", 64'(rsp_valid), 64'd1);
            check("stall_ready", 64'(req_ready), 64'd0);
            check("stall_id",    64'(rsp_id),    64'(id));
            check("stall_sum",   64'(rsp_sum),   64'(s));
            check("stall_co",    64'(rsp_co),    64'(c));
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_id",    64'(rsp_id),    64'(id));
        check("rsp_sum",   64'(rsp_sum),   64'(s));
        check("rsp_co",    64'(rsp_co),    64'(c));
        tick();
        check("post_valid", 64'(rsp_valid), 64'd0);
        exp_ops++;
        if (c) exp_cos++;
    endtask

    function automatic int pick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < 4; k++)
            if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
        return 0;
    endfunction

    initial begin
        logic [31:0] ra, rb;
        logic        rci, ec;
        logic [32:0] full;
        logic [3:0]  mask;
        int          w;

        rst       = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        req_ci    = '0;
        rsp_ready = 1'b1;

        // Reset with every requester asking
        tick();
        tick();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id",    64'(rsp_id),    64'd0);
        check("rst_rsp_sum",   64'(rsp_sum),   64'd0);
        check("rst_rsp_co",    64'(rsp_co),    64'd0);
        check_stats("rst");
        rst       = 1'b0;
        req_valid = 4'h0;
        tick();
        check("idle_no_valid", 64'(req_ready), 64'd0);

        // Single op from requester 2
        set_op(2, 32'h0000_0005, 32'h0000_0003, 1'b1);
        req_valid = 4'b0100;
        do_op(4'b0100, 2'd2, 32'h0000_0009, 1'b0, 0);

        // Search resumes at 3; carry out with wrap to zero
        set_op(3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        req_valid = 4'b1001;
        do_op(4'b1000, 2'd3, 32'h0000_0000, 1'b1, 0);
        req_valid = 4'b0001;
        do_op(4'b0001, 2'd0, 32'hFFFF_FFFF, 1'b1, 0);
        check_stats("carry");

        // Reset during EXEC discards the op and returns the pointer to 0
        set_op(1, 32'h0000_1000, 32'h0000_0234, 1'b0);
        req_valid = 4'b0010;
        #1;
        check("midrst_grant", 64'(req_ready), 64'b0010);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_valid_in_rst", 64'(rsp_valid), 64'd0);
        check("midrst_ready_in_rst", 64'(req_ready), 64'd0);
        rst       = 1'b0;
        req_valid = 4'h0;
        exp_ops   = 0;
        exp_cos   = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        check_stats("midrst");

        // Round-robin with all requesters valid: 0,1,2,3,0
        for (int i = 0; i < 4; i++)
            set_op(i, 32'(i + 1), 32'((i + 1) << 4), 1'b0);
        req_valid = 4'hF;
        for (int n = 0; n < 5; n++)
            do_op(4'(1 << (n % 4)), 2'(n % 4), 32'(17 * ((n % 4) + 1)), 1'b0, 0);

        // Backpressure: requester 1 result held for 10 cycles
        set_op(1, 32'h8000_0000, 32'h8000_0000, 1'b1);
        req_valid = 4'b0010;
        do_op(4'b0010, 2'd1, 32'h0000_0001, 1'b1, 10);
        check_stats("bp");
        req_valid = 4'h0;
        mptr      = 2;

        // Random operands, masks and stalls against a per-id golden sum
        for (int n = 0; n < 1000; n++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                ra  = $urandom;
                rb  = $urandom;
                rci = 1'($urandom_range(0, 1));
                set_op(i, ra, rb, rci);
            end
            w    = pick(mask, mptr);
            full = {1'b0, req_a[w*32 +: 32]} + {1'b0, req_b[w*32 +: 32]} + {32'd0, req_ci[w]};
            ec   = full[32];
            req_valid = mask;
            do_op(4'(1 << w), 2'(w), full[31:0], ec, $urandom_range(0, 2));
            mptr = (w + 1) % 4;
        end
        check_stats("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
